pipe_stage_buffer: RTL and testbench

Parametrised elastic pipeline-stage register that replaces the fixed per-stage buffers between decode/execute, execute/memory and memory/writeback. It holds up to two instructions (a main entry plus a skid entry) per stage, using a valid/ready handshake, and supports a global write enable, a synchronous flush and no-op bubbles. Control fields are forced to zero on bubbles, so write enables can never leak downstream. A saturating stall counter is included for performance debug.

---
 rtl/pipe_stage_buffer.sv | 105 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Elastic two-entry pipeline stage (main + skid) with valid/ready handshake,
// flush, bubble masking and a saturating stall counter.
module pipe_stage_buffer #(
  parameter int DBITS    = 32,
  parameter int CTRLBITS = 12,
  parameter int CNTBITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wrtEn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_noop,
  input  logic [DBITS-1:0]    in_data,
  input  logic [CTRLBITS-1:0] in_ctrl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_noop,
  output logic [DBITS-1:0]    out_data,
  output logic [CTRLBITS-1:0] out_ctrl,
  output logic [1:0]          count,
  output logic [CNTBITS-1:0]  stall_cnt
);

  logic [1:0]          r_cnt;
  logic                r_m_noop;
  logic [DBITS-1:0]    r_m_data;
  logic [CTRLBITS-1:0] r_m_ctrl;
  logic                r_s_noop;
  logic [DBITS-1:0]    r_s_data;
  logic [CTRLBITS-1:0] r_s_ctrl;
  logic [CNTBITS-1:0]  r_stall;

  logic w_push;
  logic w_pop;
  logic w_stall;

  assign in_ready  = (r_cnt != 2'd2);
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid && in_ready && wrtEn;
  assign w_pop     = out_valid && out_ready && wrtEn;
  assign w_stall   = out_valid && !out_ready && wrtEn;

  // Outputs mirror main; an empty stage looks like a zeroed bubble.
  assign out_noop  = !out_valid || r_m_noop;
  assign out_data  = out_valid ? r_m_data : '0;
  assign out_ctrl  = out_noop ? '0 : r_m_ctrl;
  assign count     = r_cnt;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 2'd0;
      r_m_noop <= 1'b0;
      r_m_data <= '0;
      r_m_ctrl <= '0;
      r_s_noop <= 1'b0;
      r_s_data <= '0;
      r_s_ctrl <= '0;
      r_stall  <= '0;
    end else begin
      if (w_stall && (r_stall != {CNTBITS{1'b1}}))
        r_stall <= r_stall + {{(CNTBITS-1){1'b0}}, 1'b1};
      if (flush) begin
        r_cnt <= 2'd0;
      end else begin
        case (r_cnt)
          2'd0: begin
            if (w_push) begin
              r_m_noop <= in_noop;
              r_m_data <= in_data;
              r_m_ctrl <= in_ctrl;
              r_cnt    <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push && w_pop) begin
              r_m_noop <= in_noop;
              r_m_data <= in_data;
              r_m_ctrl <= in_ctrl;
            end else if (w_push) begin
              r_s_noop <= in_noop;
              r_s_data <= in_data;
              r_s_ctrl <= in_ctrl;
              r_cnt    <= 2'd2;
            end else if (w_pop) begin
              r_cnt <= 2'd0;
            end
          end
          2'd2: begin
            if (w_pop) begin
              r_m_noop <= r_s_noop;
              r_m_data <= r_s_data;
              r_m_ctrl <= r_s_ctrl;
              r_cnt    <= 2'd1;
            end
          end
          default: r_cnt <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Randomised bench for pipe_stage_buffer: queue-based model, per-cycle
// compare process and a few hand-computed literal checks.
module tb_pipe_stage_buffer;

  localparam int DB = 32;
  localparam int CB = 12;
  localparam int NB = 4;
  localparam int SMAX = (1 << NB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wrtEn = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_noop = 1'b0;
  logic [DB-1:0] in_data = '0;
  logic [CB-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_noop;
  logic [DB-1:0] out_data;
  logic [CB-1:0] out_ctrl;
  logic [1:0]    count;
  logic [NB-1:0] stall_cnt;

  pipe_stage_buffer #(.DBITS(DB), .CTRLBITS(CB), .CNTBITS(NB)) dut (
    .clk(clk), .reset(reset), .wrtEn(wrtEn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_noop(in_noop),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_noop(out_noop), .out_data(out_data),
    .out_ctrl(out_ctrl), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          noop;
    logic [DB-1:0] d;
    logic [CB-1:0] c;
  } item_t;

  item_t q[$];
  int    mstall = 0;
  int    n_m;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: occupancy is a queue of at most two items.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      mstall = 0;
    end else begin
      n_m = q.size();
      if (n_m > 0 && !out_ready && wrtEn && mstall < SMAX) mstall++;
      if (flush) q.delete();
      else if (wrtEn) begin
        if (n_m > 0 && out_ready) void'(q.pop_front());
        if (in_valid && n_m < 2) q.push_back('{in_noop, in_data, in_ctrl});
      end
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
    if (q.size() == 0) begin
      chk("out_noop", 32'(out_noop), 32'd1);
      chk("out_data", 32'(out_data), 32'd0);
      chk("out_ctrl", 32'(out_ctrl), 32'd0);
    end else begin
      chk("out_noop", 32'(out_noop), 32'(q[0].noop));
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_ctrl", 32'(out_ctrl), q[0].noop ? 32'd0 : 32'(q[0].c));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit nop, input logic [DB-1:0] d,
                       input logic [CB-1:0] c);
    in_valid = v;
    in_noop  = nop;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    #3;
    chk("rst_noop", 32'(out_noop), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // pass-through
    out_ready = 1'b1;
    drive(1, 0, 32'd1, 12'h0C3);
    tick();
    chk("pt_valid", 32'(out_valid), 32'd1);
    chk("pt_data", 32'(out_data), 32'd1);
    chk("pt_ctrl", 32'(out_ctrl), 32'h0C3);
    chk("pt_count", 32'(count), 32'd1);
    drive(0, 0, 0, 0);
    tick();
    chk("pt_drain", 32'(count), 32'd0);

    // backpressure and skid
    out_ready = 1'b0;
    drive(1, 0, 32'd5, 12'h005);
    tick();
    chk("bp_stall0", 32'(stall_cnt), 32'd0);
    drive(1, 0, 32'd6, 12'h006);
    tick();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_data", 32'(out_data), 32'd5);
    chk("bp_stall1", 32'(stall_cnt), 32'd1);
    drive(0, 0, 0, 0);
    tick();
    chk("bp_stall2", 32'(stall_cnt), 32'd2);
    chk("bp_hold", 32'(out_data), 32'd5);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 32'(out_data), 32'd6);
    chk("bp_count1", 32'(count), 32'd1);
    tick();
    chk("bp_count0", 32'(count), 32'd0);

    // bubble masking
    out_ready = 1'b0;
    drive(1, 1, 32'hABCD, 12'hFFF);
    tick();
    chk("bub_valid", 32'(out_valid), 32'd1);
    chk("bub_noop", 32'(out_noop), 32'd1);
    chk("bub_ctrl", 32'(out_ctrl), 32'd0);
    drive(0, 0, 0, 0);
    out_ready = 1'b1;
    tick();

    // wrtEn freeze
    out_ready = 1'b0;
    drive(1, 0, 32'd9, 12'h009);
    tick();
    wrtEn = 1'b0;
    out_ready = 1'b1;
    drive(1, 0, 32'd7, 12'h007);
    repeat (3) tick();
    chk("frz_data", 32'(out_data), 32'd9);
    chk("frz_count", 32'(count), 32'd1);
    chk("frz_stall", 32'(stall_cnt), 32'd2);

    // flush beats wrtEn=0 and a same-cycle push
    wrtEn = 1'b1;
    out_ready = 1'b0;
    drive(1, 0, 32'd10, 12'h00A);
    tick();
    chk("fl_count2", 32'(count), 32'd2);
    chk("fl_stall", 32'(stall_cnt), 32'd3);
    flush = 1'b1;
    wrtEn = 1'b0;
    drive(1, 0, 32'd11, 12'h00B);
    tick();
    flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ctrl", 32'(out_ctrl), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    wrtEn = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    chk("fl_dropped", 32'(count), 32'd0);

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            $urandom, 12'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      wrtEn     = 1'($urandom_range(0, 7) != 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    wrtEn = 1'b1;

    // asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(1, 0, 32'h33, 12'h033);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();

    // stall counter saturation
    drive(1, 0, 32'h44, 12'h044);
    tick();
    drive(0, 0, 0, 0);
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    chk("sat_data", 32'(out_data), 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
